// File: rtl/fmul_pipe.sv
// rtl/fmul_pipe.sv - parametrised 3-stage floating-point multiplier, RNE/RTZ rounding, flush-to-zero
// One global enable moves all stages together; data registers carry no reset, only valid bits and outputs.
module fmul_pipe #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EW+MW:0]   x1,
  input  logic [EW+MW:0]   x2,
  input  logic             rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EW+MW:0]   y,
  output logic [3:0]       flags
);
  localparam int W  = EW + MW + 1;
  localparam int H  = (MW + 1) / 2;
  localparam int L  = MW + 1 - H;
  localparam int PW = 2 * MW + 2;
  localparam logic [EW+1:0]        BIAS = (EW+2)'((1 << (EW - 1)) - 1);
  localparam logic signed [EW+1:0] EMAX = (EW+2)'((1 << EW) - 1);

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  logic [EW-1:0] e1, e2;
  logic [MW-1:0] m1, m2;
  logic [MW:0]   sig1, sig2;
  logic          z1, z2, i1, i2, n1, n2, sgn_c;
  assign e1    = x1[W-2:MW];
  assign e2    = x2[W-2:MW];
  assign m1    = x1[MW-1:0];
  assign m2    = x2[MW-1:0];
  assign sig1  = {1'b1, m1};
  assign sig2  = {1'b1, m2};
  assign sgn_c = x1[W-1] ^ x2[W-1];
  assign z1    = (e1 == '0);
  assign z2    = (e2 == '0);
  assign i1    = (e1 == '1) && (m1 == '0);
  assign i2    = (e2 == '1) && (m2 == '0);
  assign n1    = (e1 == '1) && (m1 != '0);
  assign n2    = (e2 == '1) && (m2 != '0);

  logic signed [EW+1:0] esum_c;
  assign esum_c = $signed({2'b00, e1} + {2'b00, e2} - BIAS);

  logic         sp_c, sp_nv_c;
  logic [W-1:0] sp_y_c;
  always_comb begin
    sp_c    = 1'b1;
    sp_nv_c = 1'b0;
    sp_y_c  = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
    if (n1 | n2)
      sp_nv_c = (n1 & ~m1[MW-1]) | (n2 & ~m2[MW-1]);
    else if ((i1 & z2) | (z1 & i2))
      sp_nv_c = 1'b1;
    else if (i1 | i2)
      sp_y_c = {sgn_c, {EW{1'b1}}, {MW{1'b0}}};
    else if (z1 | z2)
      sp_y_c = {sgn_c, {(W-1){1'b0}}};
    else
      sp_c = 1'b0;
  end

  // Stage 1: split multiplier operand into two partial products
  logic                 v1, s1_sgn, s1_rm, s1_sp, s1_sp_nv;
  logic signed [EW+1:0] s1_esum;
  logic [MW+H:0]        s1_pplo;
  logic [MW+L:0]        s1_pphi;
  logic [W-1:0]         s1_sp_y;

  logic [PW-1:0]        prod;
  logic signed [EW+1:0] e_n;
  logic [MW-1:0]        mant_n;
  logic                 g_n, st_n;
  assign prod = PW'(s1_pplo) + (PW'(s1_pphi) << H);

  always_comb begin
    if (prod[PW-1]) begin
      e_n    = s1_esum + (EW+2)'(1);
      mant_n = prod[PW-2:MW+1];
      g_n    = prod[MW];
      st_n   = |prod[MW-1:0];
    end else begin
      e_n    = s1_esum;
      mant_n = prod[PW-3:MW];
      g_n    = prod[MW-1];
      st_n   = |prod[MW-2:0];
    end
  end

  logic                 v2, s2_sgn, s2_rm, s2_sp, s2_sp_nv, s2_g, s2_st;
  logic signed [EW+1:0] s2_e;
  logic [MW-1:0]        s2_mant;
  logic [W-1:0]         s2_sp_y;

  // Stage 3: a mantissa carry leaves the low bits zero, so only E needs the bump
  logic                 inc;
  logic [MW:0]          mr;
  logic signed [EW+1:0] e_r;
  logic [W-1:0]         res_y;
  logic [3:0]           res_f;
  assign inc = ~s2_rm & s2_g & (s2_st | s2_mant[0]);
  assign mr  = {1'b0, s2_mant} + {{MW{1'b0}}, inc};
  assign e_r = s2_e + {{(EW+1){1'b0}}, mr[MW]};

  always_comb begin
    res_y = {s2_sgn, e_r[EW-1:0], mr[MW-1:0]};
    res_f = {3'b000, s2_g | s2_st};
    if (s2_sp) begin
      res_y = s2_sp_y;
      res_f = {s2_sp_nv, 3'b000};
    end else if (e_r >= EMAX) begin
      res_y = {s2_sgn, {EW{1'b1}}, {MW{1'b0}}};
      res_f = 4'b0101;
    end else if (e_r[EW+1] || (e_r == '0)) begin
      res_y = {s2_sgn, {(W-1){1'b0}}};
      res_f = 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
      flags     <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      y         <= v2 ? res_y : '0;
      flags     <= v2 ? res_f : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sgn   <= sgn_c;
      s1_rm    <= rm;
      s1_esum  <= esum_c;
      s1_pplo  <= (MW+1+H)'(sig1) * (MW+1+H)'(sig2[H-1:0]);
      s1_pphi  <= (MW+1+L)'(sig1) * (MW+1+L)'(sig2[MW:H]);
      s1_sp    <= sp_c;
      s1_sp_nv <= sp_nv_c;
      s1_sp_y  <= sp_y_c;
      s2_sgn   <= s1_sgn;
      s2_rm    <= s1_rm;
      s2_e     <= e_n;
      s2_mant  <= mant_n;
      s2_g     <= g_n;
      s2_st    <= st_n;
      s2_sp    <= s1_sp;
      s2_sp_nv <= s1_sp_nv;
      s2_sp_y  <= s1_sp_y;
    end
  end
endmodule

// File: tb/tb_fmul_pipe.sv
// tb/tb_fmul_pipe.sv - randomized and directed checks of fmul_pipe against an arithmetic reference
module tb_fmul_pipe;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, in_valid, in_ready, rm, out_valid, out_ready;
  logic [31:0] x1, x2, y;
  logic [3:0]  flags;
  logic        h_in_valid, h_in_ready, h_rm, h_out_valid, h_out_ready;
  logic [15:0] h_x1, h_x2, h_y;
  logic [3:0]  h_flags;

  int n_vec = 0;
  int n_bad = 0;

  fmul_pipe dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .flags(flags)
  );

  fmul_pipe #(.EW(5), .MW(10)) dut_h (
    .clk(clk), .rstn(rstn), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .x1(h_x1), .x2(h_x2), .rm(h_rm), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .y(h_y), .flags(h_flags)
  );

  // Exact product, then round by comparing the discarded remainder with one half-ulp.
  function automatic logic [35:0] ref_mul(input int ew, input int mw, input logic [31:0] a,
                                          input logic [31:0] b, input logic r);
    int emax, bias, ea, eb, e, sh;
    longint unsigned ma, mb, p, q, rem, half;
    logic [31:0] sbit, qnan, inf;
    logic za, zb, ia, ib, na, nb, nx, nv;
    emax = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    ea   = int'((a >> mw) & 32'(emax));
    eb   = int'((b >> mw) & 32'(emax));
    ma   = longint'(a) & ((64'd1 << mw) - 1);
    mb   = longint'(b) & ((64'd1 << mw) - 1);
    sbit = (a[ew+mw] ^ b[ew+mw]) ? (32'd1 << (ew + mw)) : 32'd0;
    qnan = (32'(emax) << mw) | (32'd1 << (mw - 1));
    inf  = sbit | (32'(emax) << mw);
    za = (ea == 0);  zb = (eb == 0);
    ia = (ea == emax) && (ma == 0);  ib = (eb == emax) && (mb == 0);
    na = (ea == emax) && (ma != 0);  nb = (eb == emax) && (mb != 0);
    if (na || nb) begin
      nv = (na && ((ma >> (mw - 1)) == 0)) || (nb && ((mb >> (mw - 1)) == 0));
      return {nv, 3'b000, qnan};
    end
    if ((ia && zb) || (za && ib)) return {4'b1000, qnan};
    if (ia || ib) return {4'b0000, inf};
    if (za || zb) return {4'b0000, sbit};
    p  = ((64'd1 << mw) + ma) * ((64'd1 << mw) + mb);
    e  = ea + eb - bias;
    sh = mw;
    if (p >= (64'd1 << (2 * mw + 1))) begin
      sh = mw + 1;
      e++;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    nx   = (rem != 0);
    if (!r && ((rem > half) || (rem == half && q[0]))) q++;
    if (q == (64'd1 << (mw + 1))) begin
      q = q >> 1;
      e++;
    end
    if (e >= emax) return {4'b0101, inf};
    if (e <= 0) return {4'b0011, sbit};
    return {3'b000, nx, sbit | (32'(e) << mw) | 32'(q - (64'd1 << mw))};
  endfunction

  function automatic logic [31:0] rnd32();
    logic [7:0] e;
    e = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(97, 157)) : 8'($urandom);
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  function automatic logic [31:0] rnd16();
    logic [4:0] e;
    e = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(8, 22)) : 5'($urandom);
    return {16'h0, 1'($urandom), e, 10'($urandom)};
  endfunction

  task automatic run_op(input bit half, input logic [31:0] a, input logic [31:0] b, input logic r,
                        output logic [31:0] ry, output logic [3:0] rf, output int lat);
    logic ov;
    if (half) begin
      h_out_ready = 1'b1; h_in_valid = 1'b1; h_x1 = a[15:0]; h_x2 = b[15:0]; h_rm = r;
    end else begin
      out_ready = 1'b1; in_valid = 1'b1; x1 = a; x2 = b; rm = r;
    end
    lat = 0;
    ov  = 1'b0;
    while (!ov && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
      in_valid   = 1'b0;
      h_in_valid = 1'b0;
      ov = half ? h_out_valid : out_valid;
    end
    ry = half ? {16'h0, h_y} : y;
    rf = half ? h_flags : flags;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; h_in_valid = 1'b0; out_ready = 1'b0; h_out_ready = 1'b0;
    x1 = '0; x2 = '0; rm = 1'b0; h_x1 = '0; h_x2 = '0; h_rm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (y !== 32'h0) begin n_bad++; $display("FAIL reset_y: got %h expected 0", y); end
    n_vec++; if (flags !== 4'h0) begin n_bad++; $display("FAIL reset_flags: got %b expected 0", flags); end
    n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_vec++; if (h_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_h_out_valid: got %b expected 0", h_out_valid); end
    n_vec++; if (h_y !== 16'h0) begin n_bad++; $display("FAIL reset_h_y: got %h expected 0", h_y); end
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        r;
    logic [31:0] ey;
    logic [3:0]  ef;
  } vec_t;

  task automatic test_directed();
    vec_t tbl[$];
    logic [31:0] ry;
    logic [3:0]  rf;
    int lat;
    tbl.push_back('{32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000});
    tbl.push_back('{32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00002, 4'b0001});
    tbl.push_back('{32'h3F800001, 32'h3FC00000, 1'b1, 32'h3FC00001, 4'b0001});
    tbl.push_back('{32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 4'b0101});
    tbl.push_back('{32'h7F000000, 32'h7F000000, 1'b1, 32'h7F800000, 4'b0101});
    tbl.push_back('{32'h00800000, 32'h80800000, 1'b0, 32'h80000000, 4'b0011});
    tbl.push_back('{32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000});
    tbl.push_back('{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000});
    tbl.push_back('{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000});
    tbl.push_back('{32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 4'b0000});
    tbl.push_back('{32'h3F800000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000});
    tbl.push_back('{32'h00000001, 32'h7F800000, 1'b0, 32'h7FC00000, 4'b1000});
    foreach (tbl[i]) begin
      run_op(1'b0, tbl[i].a, tbl[i].b, tbl[i].r, ry, rf, lat);
      n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL dir%0d_latency: got %0d expected 3", i, lat); end
      n_vec++; if (ry !== tbl[i].ey) begin n_bad++; $display("FAIL dir%0d_y: got %h expected %h", i, ry, tbl[i].ey); end
      n_vec++; if (rf !== tbl[i].ef) begin n_bad++; $display("FAIL dir%0d_flags: got %b expected %b", i, rf, tbl[i].ef); end
    end
  endtask

  task automatic test_binary16();
    logic [31:0] a, b, ry;
    logic [35:0] exp_v;
    logic [3:0]  rf;
    logic        r;
    int lat;
    run_op(1'b1, 32'h3C00, 32'h3C00, 1'b0, ry, rf, lat);
    n_vec++; if ({rf, ry[15:0]} !== {4'b0000, 16'h3C00}) begin n_bad++; $display("FAIL h_one: got %b/%h expected 0000/3c00", rf, ry[15:0]); end
    run_op(1'b1, 32'h7BFF, 32'h4000, 1'b0, ry, rf, lat);
    n_vec++; if ({rf, ry[15:0]} !== {4'b0101, 16'h7C00}) begin n_bad++; $display("FAIL h_ovf: got %b/%h expected 0101/7c00", rf, ry[15:0]); end
    for (int i = 0; i < 30; i++) begin
      a = rnd16(); b = rnd16(); r = 1'($urandom);
      exp_v = ref_mul(5, 10, a, b, r);
      run_op(1'b1, a, b, r, ry, rf, lat);
      n_vec++;
      if (lat !== 3 || {rf, ry[15:0]} !== {exp_v[35:32], exp_v[15:0]}) begin
        n_bad++;
        $display("FAIL h_rand%0d: %h*%h rm=%b got %b/%h lat %0d expected %b/%h lat 3",
                 i, a[15:0], b[15:0], r, rf, ry[15:0], lat, exp_v[35:32], exp_v[15:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    localparam int N = 40;
    logic [35:0] expq[$];
    logic [35:0] e;
    logic [31:0] prev_y;
    logic [3:0]  prev_f;
    bit          prev_stall;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_y = '0; prev_f = '0;
    while ((sent < N || expq.size() != 0) && cyc < 1000) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if (sent < N && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; x1 = rnd32(); x2 = rnd32(); rm = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        n_vec++;
        if (out_valid !== 1'b1 || y !== prev_y || flags !== prev_f) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%b %h/%b expected v=1 %h/%b", out_valid, y, flags, prev_y, prev_f);
        end
      end
      n_vec++;
      if (in_ready !== (~out_valid | out_ready)) begin
        n_bad++;
        $display("FAIL in_ready: got %b expected %b", in_ready, ~out_valid | out_ready);
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (expq.size() == 0) begin
          n_bad++;
          $display("FAIL stream_extra: got %h expected no result", y);
        end else begin
          e = expq.pop_front();
          if ({flags, y} !== e) begin
            n_bad++;
            $display("FAIL stream%0d: got %b/%h expected %b/%h", got, flags, y, e[35:32], e[31:0]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(ref_mul(8, 23, x1, x2, rm));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_y = y;
      prev_f = flags;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_vec++;
    if (sent != N || got != N || expq.size() != 0) begin
      n_bad++;
      $display("FAIL stream_count: got sent=%0d received=%0d pending=%0d expected %0d/%0d/0", sent, got, expq.size(), N, N);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x1 = 32'h3FC00000; x2 = rnd32(); rm = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (y !== 32'h0) begin n_bad++; $display("FAIL midrst_y: got %h expected 0", y); end
    n_vec++; if (flags !== 4'h0) begin n_bad++; $display("FAIL midrst_flags: got %b expected 0", flags); end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_stale%0d: got out_valid %b expected 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_binary16();
    test_backpressure();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
